// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus: instruction-memory read port, controller handshake and redirect.
interface instr_fetch_queue_if;
    import instr_fetch_queue_pkg::*;

    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_rd_en, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_rd_en, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_rdata, instr_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/flush; head is registered storage.
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_data,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        head  = mem_q[rd_ptr_q];
        count = count_q;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns fetch PC, tracks fixed-latency imem reads, queues returned words.
// Optional FETCH_PERF_EN adds handshake and flush counters.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          IMEM_LAT = 2,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [IMEM_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [31:0]         pipe_pc_q [IMEM_LAT];
    logic [31:0]         pipe_pc_d [IMEM_LAT];

    logic [CW-1:0] count;
    logic [31:0]   inflight;
    logic [31:0]   occupancy;
    logic          issue, push, pop, valid;
    fetch_entry_t  head, push_data;

    // Credits cover queued plus in-flight words, so a returning word always has a slot.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < IMEM_LAT; i++) begin
            inflight = inflight + 32'(pipe_vld_q[i]);
        end
        occupancy = inflight + 32'(count);
        issue     = !rst && !bus.redirect && (occupancy < 32'(DEPTH));
        push      = pipe_vld_q[IMEM_LAT-1] && !bus.redirect;
        valid     = (count != '0) && !bus.redirect;
        pop       = valid && bus.instr_ready;
        push_data = '{instr: bus.imem_rdata, pc: pipe_pc_q[IMEM_LAT-1]};
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        pipe_vld_d    = '0;
        pipe_pc_d     = pipe_pc_q;
        pipe_vld_d[0] = issue;
        pipe_pc_d[0]  = fetch_pc_q;
        for (int unsigned i = 1; i < IMEM_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_pc_d[i]  = pipe_pc_q[i-1];
        end
        if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        // Clearing valid bits drops every stale return still travelling the pipe.
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc & ~32'h3;
            pipe_vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= PC_RESET;
            pipe_vld_q <= '0;
            pipe_pc_q  <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_pc_q  <= pipe_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (bus.redirect),
        .push_data(push_data),
        .head     (head),
        .count    (count)
    );

    always_comb begin
        bus.imem_rd_en  = issue;
        bus.imem_addr   = fetch_pc_q;
        bus.instr_valid = valid;
        bus.instr_out   = head.instr;
        bus.instr_pc    = head.pc;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_flushed_d = perf_flushed_q;
        if (bus.redirect) begin
            perf_flushed_d = perf_flushed_q + occupancy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    always_comb begin
        perf_fetched = perf_fetched_q;
        perf_flushed = perf_flushed_q;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4, IMEM_LAT=2) with a 2-cycle memory model.
module tb_instr_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_fetch_queue_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    instr_fetch_queue #(
        .DEPTH   (4),
        .IMEM_LAT(2),
        .PC_RESET(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    // Memory returns addr ^ KEY two cycles after the address is presented.
    logic [31:0] m_addr0, m_addr1;
    always @(posedge clk) begin
        m_addr0 <= bus.imem_addr;
        m_addr1 <= m_addr0;
    end
    assign bus.imem_rdata = m_addr1 ^ KEY;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        tick();
        tick();
        #1;
        checks++; if (bus.imem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", bus.imem_rd_en); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
        checks++; if (bus.instr_out !== 32'h0) begin failures++; $display("FAIL reset_instr_out got=%h exp=0", bus.instr_out); end
        checks++; if (bus.instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=0", bus.instr_pc); end
        tick();
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++; if (bus.imem_rd_en !== 1'b1) begin failures++; $display("FAIL stream_rd_en k=%0d got=%b exp=1", k, bus.imem_rd_en); end
            checks++; if (bus.imem_addr !== 32'(4 * k)) begin failures++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, bus.imem_addr, 32'(4 * k)); end
            if (k < 3) begin
                checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL stream_latency k=%0d got=%b exp=0", k, bus.instr_valid); end
            end else begin
                exp_pc = 32'(4 * (k - 3));
                checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, bus.instr_valid); end
                checks++; if (bus.instr_pc !== exp_pc) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus.instr_pc, exp_pc); end
                checks++; if (bus.instr_out !== (exp_pc ^ KEY)) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, bus.instr_out, exp_pc ^ KEY); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pc;
        bus.instr_ready = 1'b0;
        for (int j = 0; j < 12; j++) begin
            #1;
            if (j == 0) begin
                checks++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h30) begin failures++; $display("FAIL bp_last_issue got=%b/%h exp=1/00000030", bus.imem_rd_en, bus.imem_addr); end
            end else begin
                checks++; if (bus.imem_rd_en !== 1'b0) begin failures++; $display("FAIL bp_no_issue j=%0d got=%b exp=0", j, bus.imem_rd_en); end
            end
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h24) begin failures++; $display("FAIL bp_hold j=%0d got=%b/%h exp=1/00000024", j, bus.instr_valid, bus.instr_pc); end
            tick();
        end
        bus.instr_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            exp_pc = 32'h24 + 32'(4 * j);
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc) begin failures++; $display("FAIL bp_release j=%0d got=%b/%h exp=1/%h", j, bus.instr_valid, bus.instr_pc, exp_pc); end
            checks++; if (bus.instr_out !== (exp_pc ^ KEY)) begin failures++; $display("FAIL bp_release_instr j=%0d got=%h exp=%h", j, bus.instr_out, exp_pc ^ KEY); end
            if (j == 0) begin
                checks++; if (bus.imem_rd_en !== 1'b0) begin failures++; $display("FAIL bp_full_credit got=%b exp=0", bus.imem_rd_en); end
            end
            if (j == 1) begin
                checks++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h34) begin failures++; $display("FAIL bp_resume got=%b/%h exp=1/00000034", bus.imem_rd_en, bus.imem_addr); end
            end
            tick();
        end
    endtask

    task automatic test_redirect;
        logic [31:0] exp_pc;
        int got;
        bus.instr_ready = 1'b0;
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        bus.instr_ready = 1'b1;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_rd_en !== 1'b0) begin failures++; $display("FAIL redir_rd_en got=%b exp=0", bus.imem_rd_en); end
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h100) begin failures++; $display("FAIL redir_target got=%b/%h exp=1/00000100", bus.imem_rd_en, bus.imem_addr); end
        tick();
        exp_pc = 32'h100;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (bus.instr_valid === 1'b1) begin
                checks++; if (bus.instr_pc !== exp_pc || bus.instr_out !== (exp_pc ^ KEY)) begin failures++; $display("FAIL redir_seq got=%h/%h exp=%h/%h", bus.instr_pc, bus.instr_out, exp_pc, exp_pc ^ KEY); end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            tick();
        end
        checks++; if (got != 3) begin failures++; $display("FAIL redir_timeout got=%0d exp=3", got); end
    endtask

    task automatic test_back_to_back_redirect;
        logic [31:0] exp_pc;
        int got;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        #1;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_rd_en !== 1'b0) begin failures++; $display("FAIL b2b_first got=%b/%b exp=0/0", bus.instr_valid, bus.imem_rd_en); end
        tick();
        bus.redirect_pc = 32'h301;
        #1;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_rd_en !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b/%b exp=0/0", bus.instr_valid, bus.imem_rd_en); end
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h300) begin failures++; $display("FAIL b2b_target got=%b/%h exp=1/00000300", bus.imem_rd_en, bus.imem_addr); end
        tick();
        exp_pc = 32'h300;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            #1;
            if (bus.instr_valid === 1'b1) begin
                checks++; if (bus.instr_pc !== exp_pc || bus.instr_out !== (exp_pc ^ KEY)) begin failures++; $display("FAIL b2b_seq got=%h/%h exp=%h/%h", bus.instr_pc, bus.instr_out, exp_pc, exp_pc ^ KEY); end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            tick();
        end
        checks++; if (got != 4) begin failures++; $display("FAIL b2b_timeout got=%0d exp=4", got); end
    endtask

    task automatic test_reset_midstream;
        logic [31:0] exp_pc;
        int got;
        int first_c;
        bus.instr_ready = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        #1;
        checks++; if (bus.imem_rd_en !== 1'b0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL mrst_ctrl got=%b/%b exp=0/0", bus.imem_rd_en, bus.instr_valid); end
        checks++; if (bus.instr_out !== 32'h0 || bus.instr_pc !== 32'h0 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL mrst_data got=%h/%h/%h exp=0/0/0", bus.instr_out, bus.instr_pc, bus.imem_addr); end
        tick();
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        checks++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL mrst_restart got=%b/%h exp=1/00000000", bus.imem_rd_en, bus.imem_addr); end
        tick();
        exp_pc = 32'h0;
        got = 0;
        first_c = -1;
        for (int c = 1; c < 20 && got < 3; c++) begin
            #1;
            if (bus.instr_valid === 1'b1) begin
                if (first_c < 0) first_c = c;
                checks++; if (bus.instr_pc !== exp_pc || bus.instr_out !== (exp_pc ^ KEY)) begin failures++; $display("FAIL mrst_seq got=%h/%h exp=%h/%h", bus.instr_pc, bus.instr_out, exp_pc, exp_pc ^ KEY); end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            tick();
        end
        checks++; if (first_c != 3) begin failures++; $display("FAIL mrst_latency got=%0d exp=3", first_c); end
        checks++; if (got != 3) begin failures++; $display("FAIL mrst_timeout got=%0d exp=3", got); end
    endtask

    task automatic test_pc_wrap;
        logic [31:0] exp_pc;
        int got;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_a0 got=%h exp=fffffff8", bus.imem_addr); end
        tick();
        #1;
        checks++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_a1 got=%b/%h exp=1/fffffffc", bus.imem_rd_en, bus.imem_addr); end
        tick();
        #1;
        checks++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_a2 got=%b/%h exp=1/00000000", bus.imem_rd_en, bus.imem_addr); end
        tick();
        exp_pc = 32'hFFFF_FFF8;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            #1;
            if (bus.instr_valid === 1'b1) begin
                checks++; if (bus.instr_pc !== exp_pc) begin failures++; $display("FAIL wrap_seq got=%h exp=%h", bus.instr_pc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            tick();
        end
        checks++; if (got != 4) begin failures++; $display("FAIL wrap_timeout got=%0d exp=4", got); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf;
        int got;
        rst = 1'b1;
        bus.redirect = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        checks++; if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0) begin failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_fetched, perf_flushed); end
        tick();
        got = 0;
        for (int c = 0; c < 30 && got < 10; c++) begin
            #1;
            if (bus.instr_valid === 1'b1) got++;
            tick();
        end
        checks++; if (got != 10) begin failures++; $display("FAIL perf_timeout got=%0d exp=10", got); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        bus.instr_ready = 1'b0;
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (perf_fetched !== 32'd10) begin failures++; $display("FAIL perf_fetched got=%0d exp=10", perf_fetched); end
        checks++; if (perf_flushed !== 32'd3) begin failures++; $display("FAIL perf_flushed got=%0d exp=3", perf_flushed); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back_redirect();
        test_reset_midstream();
        test_pc_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
